transport_receive: RTL

//  Receive side of the transport layer. Accepts the byte stream produced by transportSend.

---
 rtl/transport_receive_if.sv | 21 ++
 rtl/transport_receive.sv | 125 ++++++++++++
 2 files changed

// File: rtl/transport_receive_if.sv
// Byte-stream and word-delivery bundle between the link receiver, transport_receive and the upper layer.
// The master modport drives bytes in and reads words out; the slave modport is the receiver's view.
interface transport_receive_if;
   logic [7:0]  packetIn;
   logic        byteValid;
   logic [1:0]  cmd;
   logic [15:0] data;
   logic        dataValid;
   logic        busy;
   logic        pktErr;

   modport master (
      output packetIn, byteValid,
      input  cmd, data, dataValid, busy, pktErr
   );

   modport slave (
      input  packetIn, byteValid,
      output cmd, data, dataValid, busy, pktErr
   );
endinterface

// File: rtl/transport_receive.sv
// Transport-layer receiver: delineates fixed-length packets, decodes control/audio words, aborts on idle timeout.
// Optional macro TRANSPORT_RX_PADCHECK_EN adds reserved-bit and pad-byte checking (one pktErr per packet).
module transport_receive #(
   parameter int PACKET_BYTES   = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                clk,
   input logic                reset,
   transport_receive_if.slave bus
);

`ifdef TRANSPORT_RX_PADCHECK_EN
   localparam bit PADCHECK = 1'b1;
`else
   localparam bit PADCHECK = 1'b0;
`endif

   localparam int CNT_W  = $clog2(PACKET_BYTES);
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(PACKET_BYTES - 1);
   localparam logic [CNT_W-1:0]  AUDIO_LAST = CNT_W'(PACKET_BYTES - 2);
   localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, CTRL, AUDIO, DROP} state_t;

   state_t            r_state, w_next_state;
   logic [CNT_W-1:0]  r_byte_cnt, w_byte_cnt_next;
   logic [IDLE_W-1:0] r_idle_cnt;
   logic [7:0]        r_hi;
   logic [1:0]        r_cmd;
   logic [15:0]       r_data;
   logic              r_data_valid, r_pkt_err, r_err_seen;
   logic              w_word_done, w_hi_load, w_pkt_err, w_err_seen_next;
   logic              w_in_payload, w_pad_bad;

   // NOTE: state-holding logic uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: every combinational output gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      w_next_state    = r_state;
      w_byte_cnt_next = r_byte_cnt;
      w_word_done     = 1'b0;
      w_hi_load       = 1'b0;
      w_pkt_err       = 1'b0;
      w_pad_bad       = 1'b0;
      w_err_seen_next = r_err_seen;
      w_in_payload    = (r_byte_cnt != '0) &&
                        (r_byte_cnt <= ((r_state == CTRL) ? CNT_W'(2) : AUDIO_LAST));

      if (bus.byteValid) begin
         if (r_state == IDLE) begin
            w_byte_cnt_next = CNT_W'(1);
            w_pad_bad       = PADCHECK && (bus.packetIn[5:0] != 6'd0);
            unique case (bus.packetIn[7:6])
               2'b01:   w_next_state = CTRL;
               2'b10:   w_next_state = AUDIO;
               default: begin
                  w_next_state = DROP;
                  w_pkt_err    = 1'b1;
               end
            endcase
            w_pkt_err       = w_pkt_err | w_pad_bad;
            w_err_seen_next = w_pkt_err;
         end else begin
            if (r_byte_cnt == LAST_IDX) begin
               w_next_state    = IDLE;
               w_byte_cnt_next = '0;
            end else begin
               w_byte_cnt_next = r_byte_cnt + CNT_W'(1);
            end
            if (r_state != DROP) begin
               if (w_in_payload) begin
                  w_hi_load   = r_byte_cnt[0];
                  w_word_done = !r_byte_cnt[0];
               end else begin
                  w_pad_bad = PADCHECK && (bus.packetIn != 8'h00);
               end
            end
            w_pkt_err       = w_pad_bad && !r_err_seen;
            w_err_seen_next = r_err_seen | w_pad_bad;
         end
      end else if (r_state != IDLE && r_idle_cnt == IDLE_MAX) begin
         // Timeout abandons the packet, including any half-received word in r_hi.
         w_next_state    = IDLE;
         w_byte_cnt_next = '0;
         w_pkt_err       = 1'b1;
      end
   end

   // NOTE: this block holds only a few control/data flops, so all of them are reset; nothing here is a memory.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_byte_cnt   <= '0;
         r_idle_cnt   <= '0;
         r_hi         <= '0;
         r_cmd        <= '0;
         r_data       <= '0;
         r_data_valid <= 1'b0;
         r_pkt_err    <= 1'b0;
         r_err_seen   <= 1'b0;
      end else begin
         r_byte_cnt   <= w_byte_cnt_next;
         r_idle_cnt   <= (bus.byteValid || w_next_state == IDLE) ? '0 : r_idle_cnt + IDLE_W'(1);
         r_data_valid <= w_word_done;
         r_pkt_err    <= w_pkt_err;
         r_err_seen   <= w_err_seen_next;
         if (w_hi_load) r_hi <= bus.packetIn;
         if (w_word_done) begin
            r_cmd  <= (r_state == CTRL) ? 2'b01 : 2'b10;
            r_data <= {r_hi, bus.packetIn};
         end
      end
   end

   assign bus.cmd       = r_cmd;
   assign bus.data      = r_data;
   assign bus.dataValid = r_data_valid;
   assign bus.pktErr    = r_pkt_err;
   assign bus.busy      = (r_state != IDLE);

endmodule
